// File: rtl/posicionador_pecas_param.sv
// Piece-placement controller for the Batalha Naval setup phase: walks each player
// through direction, orientation and X/Y selection, then handshakes with validator and memory.
module posicionador_pecas_param #(
  parameter int BOARD_W = 8,
  parameter int COORD_W = 4,
  parameter int N_TIPOS = 5,
  parameter int QTD_W = 3,
  parameter logic [N_TIPOS*QTD_W-1:0] QTD_TIPOS = {3'd1, 3'd1, 3'd2, 3'd2, 3'd5},
  parameter int N_ORIENT = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               enter_n,
  input  logic               select_n,
  input  logic               mode,
  input  logic [BOARD_W-1:0] sw,
  input  logic               conflito,
  input  logic               val_done,
  input  logic               wr_ack,
  output logic [COORD_W-1:0] X1,
  output logic [COORD_W-1:0] Y1,
  output logic [2:0]         tipo,
  output logic [QTD_W-1:0]   qtd,
  output logic               direcao,
  output logic [2:0]         orientacao,
  output logic               jogador,
  output logic               valida,
  output logic               grava,
  output logic               ready,
  output logic               erro,
  output logic [2:0]         estado
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] DIR    = 3'd1;
  localparam logic [2:0] ORIENT = 3'd2;
  localparam logic [2:0] DEF_X  = 3'd3;
  localparam logic [2:0] DEF_Y  = 3'd4;
  localparam logic [2:0] VALIDA = 3'd5;
  localparam logic [2:0] GRAVA  = 3'd6;
  localparam logic [2:0] PRONTO = 3'd7;

  logic [2:0] state;

  logic enter_p0, enter_p1, enter_p2, enter_pulse_p3;
  logic select_p0, select_p1, select_p2, select_pulse_p3;
  logic ent, sel;
  logic [QTD_W:0] qtd_inc;

  function automatic logic is_one_hot(input logic [BOARD_W-1:0] v);
    return (v != '0) && ((v & (v - BOARD_W'(1))) == '0);
  endfunction

  // Bit BOARD_W-1 is coordinate 1, bit 0 is coordinate BOARD_W.
  function automatic logic [COORD_W-1:0] coord_of(input logic [BOARD_W-1:0] v);
    logic [COORD_W-1:0] c;
    c = '0;
    for (int i = 0; i < BOARD_W; i++)
      if (v[i]) c = COORD_W'(BOARD_W - i);
    return c;
  endfunction

  function automatic logic [QTD_W-1:0] count_of(input logic [2:0] t);
    logic [QTD_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_TIPOS; i++)
      if (t == 3'(i)) c = QTD_TIPOS[i*QTD_W +: QTD_W];
    return c;
  endfunction

  // Stage p0/p1: synchronisers; p2: delay for edge detect; p3: registered press pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      enter_p0        <= 1'b1;
      enter_p1        <= 1'b1;
      enter_p2        <= 1'b1;
      enter_pulse_p3  <= 1'b0;
      select_p0       <= 1'b1;
      select_p1       <= 1'b1;
      select_p2       <= 1'b1;
      select_pulse_p3 <= 1'b0;
    end else begin
      enter_p0        <= enter_n;
      enter_p1        <= enter_p0;
      enter_p2        <= enter_p1;
      enter_pulse_p3  <= enter_p2 & ~enter_p1;
      select_p0       <= select_n;
      select_p1       <= select_p0;
      select_p2       <= select_p1;
      select_pulse_p3 <= select_p2 & ~select_p1;
    end
  end

  // Enter wins over a simultaneous select.
  assign ent = enable & enter_pulse_p3;
  assign sel = enable & select_pulse_p3 & ~enter_pulse_p3;
  assign qtd_inc = {1'b0, qtd} + {{QTD_W{1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      X1         <= '0;
      Y1         <= '0;
      tipo       <= '0;
      qtd        <= '0;
      direcao    <= 1'b0;
      orientacao <= '0;
      jogador    <= 1'b0;
      erro       <= 1'b0;
    end else if (enable) begin
      case (state)
        IDLE: state <= DIR;
        DIR: begin
          if (ent) state <= ORIENT;
          else if (sel) direcao <= ~direcao;
        end
        ORIENT: begin
          if (ent) state <= DEF_X;
          else if (sel) orientacao <= (orientacao == 3'(N_ORIENT - 1)) ? 3'd0 : orientacao + 3'd1;
        end
        DEF_X: begin
          if (ent) begin
            if (is_one_hot(sw)) begin
              X1    <= coord_of(sw);
              erro  <= 1'b0;
              state <= DEF_Y;
            end else begin
              erro <= 1'b1;
            end
          end
        end
        DEF_Y: begin
          if (ent) begin
            if (is_one_hot(sw)) begin
              Y1    <= coord_of(sw);
              erro  <= 1'b0;
              state <= VALIDA;
            end else begin
              erro <= 1'b1;
            end
          end
        end
        VALIDA: begin
          if (val_done) state <= conflito ? DEF_X : GRAVA;
        end
        GRAVA: begin
          if (wr_ack) begin
            if (qtd_inc < {1'b0, count_of(tipo)}) begin
              qtd   <= qtd_inc[QTD_W-1:0];
              state <= DIR;
            end else begin
              qtd <= '0;
              if (tipo != 3'(N_TIPOS - 1)) begin
                tipo  <= tipo + 3'd1;
                state <= DIR;
              end else if (mode && !jogador) begin
                jogador <= 1'b1;
                tipo    <= '0;
                state   <= DIR;
              end else begin
                state <= PRONTO;
              end
            end
          end
        end
        default: state <= PRONTO;
      endcase
    end
  end

  assign valida = (state == VALIDA);
  assign grava  = (state == GRAVA);
  assign ready  = (state == PRONTO);
  assign estado = state;

endmodule

// File: tb/tb_posicionador_pecas_param.sv
// Directed self-checking bench for posicionador_pecas_param: key timing, selection,
// coordinate decode, validator/memory handshakes, fleet sequencing and reset.
module tb_posicionador_pecas_param;

  logic       clk = 1'b0;
  logic       reset, enable, enter_n, select_n, mode;
  logic [7:0] sw;
  logic       conflito, val_done, wr_ack;
  logic [3:0] X1, Y1;
  logic [2:0] tipo;
  logic [2:0] qtd;
  logic       direcao;
  logic [2:0] orientacao;
  logic       jogador, valida, grava, ready, erro;
  logic [2:0] estado;

  int checks = 0;
  int errors = 0;
  int vcnt;
  int exp_tipo [1:10];
  int exp_qtd  [1:10];

  posicionador_pecas_param dut (
    .clk(clk), .reset(reset), .enable(enable), .enter_n(enter_n), .select_n(select_n),
    .mode(mode), .sw(sw), .conflito(conflito), .val_done(val_done), .wr_ack(wr_ack),
    .X1(X1), .Y1(Y1), .tipo(tipo), .qtd(qtd), .direcao(direcao), .orientacao(orientacao),
    .jogador(jogador), .valida(valida), .grava(grava), .ready(ready), .erro(erro),
    .estado(estado)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic e, input logic s);
    enter_n  = ~e;
    select_n = ~s;
    tick(2);
    enter_n  = 1'b1;
    select_n = 1'b1;
    tick(4);
  endtask

  task automatic pulse_val(input logic c);
    val_done = 1'b1;
    conflito = c;
    tick(1);
    val_done = 1'b0;
    conflito = 1'b0;
  endtask

  task automatic pulse_ack();
    wr_ack = 1'b1;
    tick(1);
    wr_ack = 1'b0;
  endtask

  task automatic place_piece(input logic do_ack);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    sw = 8'b0100_0000;
    press(1'b1, 1'b0);
    sw = 8'b0000_1000;
    press(1'b1, 1'b0);
    tick(1);
    pulse_val(1'b0);
    tick(1);
    if (do_ack) pulse_ack();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  initial begin
    exp_tipo = '{0, 0, 0, 0, 1, 1, 2, 2, 3, 4};
    exp_qtd  = '{1, 2, 3, 4, 0, 1, 0, 1, 0, 0};
    reset = 1'b1; enable = 1'b0; enter_n = 1'b1; select_n = 1'b1; mode = 1'b0;
    sw = '0; conflito = 1'b0; val_done = 1'b0; wr_ack = 1'b0;
    tick(3);
    check("rst_estado", 32'(estado), 0);
    check("rst_valida", 32'(valida), 0);
    check("rst_grava", 32'(grava), 0);
    check("rst_ready", 32'(ready), 0);
    check("rst_X1", 32'(X1), 0);
    check("rst_tipo", 32'(tipo), 0);
    check("rst_erro", 32'(erro), 0);
    reset = 1'b0;
    tick(2);
    check("idle_hold", 32'(estado), 0);
    enable = 1'b1;
    tick(1);
    check("idle_to_dir", 32'(estado), 1);

    // Disabled: select press must not change anything
    enable = 1'b0;
    press(1'b0, 1'b1);
    enable = 1'b1;
    check("freeze_dir", 32'(direcao), 0);
    press(1'b0, 1'b1);
    check("dir_sel1", 32'(direcao), 1);
    press(1'b0, 1'b1);
    check("dir_sel2", 32'(direcao), 0);

    // Enter latency: low before edge k, state changes at edge k+3
    enter_n = 1'b0;
    tick(3);
    check("lat_k2", 32'(estado), 1);
    tick(1);
    check("lat_k3", 32'(estado), 2);
    enter_n = 1'b1;
    tick(4);

    for (int i = 0; i < 4; i++) press(1'b0, 1'b1);
    check("orient_4", 32'(orientacao), 4);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    check("orient_wrap", 32'(orientacao), 1);
    press(1'b1, 1'b0);
    check("to_defx", 32'(estado), 3);

    sw = 8'b0010_0000;
    press(1'b1, 1'b0);
    check("x1_dec", 32'(X1), 3);
    check("x1_erro", 32'(erro), 0);
    check("to_defy", 32'(estado), 4);
    sw = 8'b0000_0000;
    press(1'b1, 1'b0);
    check("y_zero_erro", 32'(erro), 1);
    check("y_zero_stay", 32'(estado), 4);
    sw = 8'b0000_0011;
    press(1'b1, 1'b0);
    check("y_two_erro", 32'(erro), 1);
    check("y_two_Y1", 32'(Y1), 0);
    sw = 8'b0000_0001;
    press(1'b1, 1'b0);
    check("y1_dec", 32'(Y1), 8);
    check("y1_erro", 32'(erro), 0);
    check("to_valida", 32'(estado), 5);

    // Validator answers with conflict on the 5th cycle of VALIDA
    vcnt = 0;
    wr_ack = 1'b1;
    if (valida) vcnt++;
    tick(1);
    wr_ack = 1'b0;
    check("ack_in_valida", 32'(estado), 5);
    for (int i = 0; i < 3; i++) begin
      if (valida) vcnt++;
      tick(1);
    end
    if (valida) vcnt++;
    pulse_val(1'b1);
    check("valida_cycles", 32'(vcnt), 5);
    check("conf_defx", 32'(estado), 3);
    check("conf_valida_low", 32'(valida), 0);
    check("conf_X1", 32'(X1), 3);
    check("conf_orient", 32'(orientacao), 1);

    sw = 8'b0010_0000;
    press(1'b1, 1'b0);
    sw = 8'b0000_0001;
    press(1'b1, 1'b0);
    pulse_val(1'b0);
    check("to_grava", 32'(estado), 6);
    check("grava_hi", 32'(grava), 1);
    val_done = 1'b1;
    tick(2);
    val_done = 1'b0;
    check("vd_in_grava", 32'(estado), 6);
    check("grava_hold", 32'(grava), 1);
    pulse_ack();
    check("p1_estado", 32'(estado), 1);
    check("p1_grava_low", 32'(grava), 0);
    check("p1_qtd", 32'(qtd), 1);
    check("p1_dir_kept", 32'(direcao), 0);

    // mode 0: rest of the fleet
    for (int p = 2; p <= 10; p++) begin
      place_piece(1'b1);
      check($sformatf("m0_tipo_%0d", p), 32'(tipo), 32'(exp_tipo[p]));
      check($sformatf("m0_qtd_%0d", p), 32'(qtd), 32'(exp_qtd[p]));
    end
    place_piece(1'b1);
    check("m0_pronto", 32'(estado), 7);
    check("m0_ready", 32'(ready), 1);
    check("m0_jogador", 32'(jogador), 0);
    press(1'b1, 1'b0);
    check("pronto_hold", 32'(estado), 7);

    // mode 1: two fleets
    do_reset();
    mode = 1'b1;
    check("m1_dir", 32'(estado), 1);
    for (int p = 1; p <= 11; p++) place_piece(1'b1);
    check("m1_jog1", 32'(jogador), 1);
    check("m1_tipo0", 32'(tipo), 0);
    check("m1_qtd0", 32'(qtd), 0);
    check("m1_notready", 32'(ready), 0);
    for (int p = 12; p <= 21; p++) place_piece(1'b1);
    check("m1_p21_tipo", 32'(tipo), 4);
    place_piece(1'b1);
    check("m1_pronto", 32'(estado), 7);
    check("m1_ready", 32'(ready), 1);

    // Reset in the middle of a memory handshake
    do_reset();
    for (int p = 1; p <= 16; p++) place_piece(1'b1);
    check("m1b_tipo", 32'(tipo), 1);
    check("m1b_jog", 32'(jogador), 1);
    place_piece(1'b0);
    check("m1b_grava", 32'(grava), 1);
    reset = 1'b1;
    tick(1);
    check("rg_grava", 32'(grava), 0);
    check("rg_estado", 32'(estado), 0);
    check("rg_tipo", 32'(tipo), 0);
    check("rg_qtd", 32'(qtd), 0);
    check("rg_jog", 32'(jogador), 0);
    reset = 1'b0;
    tick(1);
    check("rg_dir", 32'(estado), 1);
    press(1'b1, 1'b1);
    check("both_estado", 32'(estado), 2);
    check("both_dir", 32'(direcao), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/posicionador_pecas_param.md
Name: posicionador_pecas_param

Overview:
Parametrised, fully synchronous piece-placement controller for the Batalha Naval setup phase. Walks each player through direction, orientation, X and Y selection for every ship in a configurable fleet, handshakes with the placement validator and the board memory, and raises ready when all fleets are placed. Sits between the board keys/switches and the validador/memory blocks, feeding ExecutandoJogo.

Parameters:
BOARD_W, 8, board side; width of the one-hot coordinate switch bus; coordinates 1..BOARD_W.
COORD_W, 4, width of X1/Y1; must satisfy 2^COORD_W > BOARD_W.
N_TIPOS, 5, number of ship types; tipo runs 0..N_TIPOS-1.
QTD_W, 3, bits per per-type count field.
QTD_TIPOS, {3'd1,3'd1,3'd2,3'd2,3'd5}, packed N_TIPOS*QTD_W per-type counts, type 0 in LSBs (submarino 5, cruzador 2, hidroaviao 2, encouracado 1, porta-avioes 1); each field >= 1.
N_ORIENT, 5, number of orientation codes; orientacao runs 0..N_ORIENT-1.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  1 = placement active; 0 = inputs ignored, state frozen
enter_n  in  1  active-low key, asynchronous; confirms and advances
select_n  in  1  active-low key, asynchronous; cycles direcao/orientacao
mode  in  1  0 = Player 1 x CPU (only jogador 0 places), 1 = Player 1 x Player 2
sw  in  BOARD_W  one-hot coordinate switches; bit BOARD_W-1 = coordinate 1, bit 0 = coordinate BOARD_W
conflito  in  1  validator result, sampled only with val_done
val_done  in  1  validator finished (one-cycle pulse)
wr_ack  in  1  memory write accepted (one-cycle pulse)
X1, Y1  out  COORD_W each  latched coordinates
tipo  out  3  current ship type
qtd  out  QTD_W  ships of current type already stored
direcao  out  1  0 = horizontal, 1 = vertical
orientacao  out  3  orientation code
jogador  out  1  player currently placing
valida  out  1  validator request
grava  out  1  memory write request
ready  out  1  all fleets placed; start-game
erro  out  1  last enter rejected (invalid switches)
estado  out  3  state code for LEDs/debug

Behaviour:
- Reset (sync, highest priority, any state including mid-handshake): state IDLE, all outputs 0; valida/grava drop at that same edge.
- Keys: each passes 2 sync flops plus a delay flop; press = one-cycle pulse on synced falling edge. An enter_n low setup before edge k produces the pulse at edge k+2; state update at edge k+3. Holding a key gives a single pulse. Pulses ignored while enable=0 (state, outputs held).
- enter and select pulse in the same cycle: enter acts, select dropped.
- States/estado: IDLE 0, DIR 1, ORIENT 2, DEF_X 3, DEF_Y 4, VALIDA 5, GRAVA 6, PRONTO 7.
- IDLE -> DIR when enable=1.
- DIR: select toggles direcao; enter -> ORIENT.
- ORIENT: select increments orientacao, N_ORIENT-1 wraps to 0; enter -> DEF_X.
- DEF_X / DEF_Y: on enter, if sw is exactly one-hot, X1 (resp. Y1) <= decoded 1..BOARD_W, erro <= 0, advance (DEF_X -> DEF_Y -> VALIDA); else erro <= 1, register and state unchanged.
- VALIDA: valida = 1 from the state's first cycle until the val_done cycle inclusive. On val_done: conflito=0 -> GRAVA; conflito=1 -> DEF_X, X1/Y1/direcao/orientacao retained. Keys ignored.
- GRAVA: grava = 1 until the wr_ack cycle inclusive; on wr_ack qtd+1. If qtd+1 < count[tipo]: -> DIR. Else qtd <= 0; if tipo < N_TIPOS-1: tipo+1 -> DIR. Else (fleet done): mode=1 and jogador=0 -> jogador <= 1, tipo <= 0, -> DIR; otherwise -> PRONTO. Keys ignored.
- direcao/orientacao are not cleared between pieces.
- PRONTO: ready = 1, held until reset; all inputs ignored.
- mode is sampled only at fleet completion.
- val_done or wr_ack outside its state: ignored.

Test Plan:
- Reset, enable=1, enter, select x2, enter, select x6, enter -> estado 1->2->3, direcao=0, orientacao=1 (wraps after 4).
- DEF_X with sw=8'b0010_0000, enter -> X1=3, erro=0; DEF_Y with sw=0, enter -> erro=1, estado stays 4; sw=8'b0000_0001, enter -> Y1=8, estado 5.
- VALIDA: val_done with conflito=1 after 4 cycles -> valida high 5 cycles, estado 3, X1=3 retained; retry with conflito=0 -> estado 6, grava high until wr_ack.
- mode=0, place 11 pieces with clean handshakes -> tipo 0->4 at qtd boundaries 5,2,2,1,1; after 11th wr_ack estado 7, ready=1, jogador=0.
- mode=1, 22 pieces -> jogador switches to 1 after 11th ack with tipo=0, qtd=0; ready after 22nd.
- reset during GRAVA with grava=1 -> next edge grava=0, estado 0, tipo=qtd=jogador=0; enter+select same cycle in DIR -> only advance, direcao unchanged.
